// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic pipeline register chain.
//   occ_w()        : width of an occupancy count for a given stage count
//   STAGES_MIPS    : default depth of the classic five-stage core
//   IF_ID..MEM_WB  : stage index constants for the classic core latches
//   stage_ctrl_t   : per-stage load/kill control bundle built by the parent
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int STAGES_MIPS = 5;

   localparam int IF_ID  = 0;
   localparam int ID_EX  = 1;
   localparam int EX_MEM = 2;
   localparam int MEM_WB = 3;

   // Bits needed to count 0..stages valid entries.
   function automatic int occ_w(input int stages);
      return $clog2(stages + 1);
   endfunction

   typedef struct packed {
      logic load;        // register takes a new value this edge
      logic load_valid;  // valid bit of the value being loaded
      logic kill;        // flush: clear the valid bit unconditionally
   } stage_ctrl_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// One pipeline stage: a valid bit plus a payload register.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   ctrl            : load / load_valid / kill from the parent movement logic
//   load_data       : payload offered by the source stage
//   valid, data     : registered stage contents
// Kill has priority over load. The payload only changes when a valid item is
// actually written, so bubbles leave stale (don't-care) data behind.
// -----------------------------------------------------------------------------
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  stage_ctrl_t       ctrl,
   input  logic [DATA_W-1:0] load_data,
   output logic              valid,
   output logic [DATA_W-1:0] data
);

   logic              valid_reg;
   logic [DATA_W-1:0] data_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
      end else begin
         if (ctrl.kill) begin
            valid_reg <= 1'b0;
         end else if (ctrl.load) begin
            valid_reg <= ctrl.load_valid;
         end
         if (ctrl.load && ctrl.load_valid && !ctrl.kill) begin
            data_reg <= load_data;
         end
      end
   end

   assign valid = valid_reg;
   assign data  = data_reg;

endmodule

// File: rtl/pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// pipe_stage_chain
// Elastic N-stage pipeline register chain with per-stage stall and flush,
// valid/ready back-pressure at the output and a debug single-step mode.
// Stage 0 is the youngest, stage STAGES-1 the oldest.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_data  : upstream offer into stage 0
//   in_ready          : stage 0 accepts this cycle (0 while rst is high)
//   stall_req[k]      : stage k holds its contents
//   flush[k]          : invalidate stages 0..k
//   step_mode         : 1 = advance only on step_pulse
//   step_pulse        : one-cycle advance strobe in step mode
//   out_valid/out_data/out_ready : oldest stage, downstream handshake
//   stage_valid       : valid bit of every stage
//   stage_data        : flattened payloads, stage k at [k*DATA_W +: DATA_W]
//   occupancy         : number of valid stages
//   retired           : count of out_valid & out_ready transfers (wraps)
// Optional macro PIPE_STAGE_CHAIN_PERF_EN adds:
//   stall_cycles      : cycles with en=1 and some valid stage not moving
//   bubble_cycles     : cycles with en=1 and out_valid=0
// -----------------------------------------------------------------------------
module pipe_stage_chain
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int STAGES = STAGES_MIPS,
   parameter int CNT_W  = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       in_ready,
   input  logic [STAGES-1:0]          stall_req,
   input  logic [STAGES-1:0]          flush,
   input  logic                       step_mode,
   input  logic                       step_pulse,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   input  logic                       out_ready,
   output logic [STAGES-1:0]          stage_valid,
   output logic [STAGES*DATA_W-1:0]   stage_data,
   output logic [occ_w(STAGES)-1:0]   occupancy,
   output logic [CNT_W-1:0]           retired
`ifdef PIPE_STAGE_CHAIN_PERF_EN
   ,
   output logic [CNT_W-1:0]           stall_cycles,
   output logic [CNT_W-1:0]           bubble_cycles
`endif
);

   localparam int OCC_W = occ_w(STAGES);

   logic                en;
   logic                accept;
   logic [STAGES-1:0]   valid_q;
   logic [STAGES-1:0]   moves;
   logic [STAGES-1:0]   load;
   logic [STAGES-1:0]   fmask;
   logic [DATA_W-1:0]   data_q [STAGES];
   stage_ctrl_t         ctrl [STAGES];
   logic [OCC_W-1:0]    occ_next;
   logic [CNT_W-1:0]    retired_reg;

   assign en = ~step_mode | step_pulse;

   // Movement is resolved from the oldest stage down: a stage can load when
   // it is empty or its current item is leaving, and its item leaves only if
   // the next-older stage loads (or, for the oldest, downstream is ready).
   always_comb begin : movement
      moves = '0;
      load  = '0;
      moves[STAGES-1] = valid_q[STAGES-1] & ~stall_req[STAGES-1] & out_ready & en;
      load[STAGES-1]  = en & ~stall_req[STAGES-1] & (~valid_q[STAGES-1] | moves[STAGES-1]);
      for (int k = STAGES - 2; k >= 0; k--) begin
         moves[k] = valid_q[k] & ~stall_req[k] & load[k+1];
         load[k]  = en & ~stall_req[k] & (~valid_q[k] | moves[k]);
      end
   end

   // A flush on stage k kills every younger stage as well.
   always_comb begin : flush_mask
      fmask = '0;
      fmask[STAGES-1] = flush[STAGES-1];
      for (int k = STAGES - 2; k >= 0; k--) begin
         fmask[k] = flush[k] | fmask[k+1];
      end
   end

   // Any flush blocks new input; rst is folded in so upstream sees no
   // acceptance while the chain is held in reset.
   assign in_ready = load[0] & ~|flush & ~rst;
   assign accept   = in_valid & in_ready;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign ctrl[gi].load       = load[gi];
            assign ctrl[gi].load_valid = accept;
            assign ctrl[gi].kill       = fmask[gi];
            pipe_stage_reg #(
               .DATA_W    (DATA_W)
            ) u_reg (
               .clk       (clk),
               .rst       (rst),
               .ctrl      (ctrl[gi]),
               .load_data (in_data),
               .valid     (valid_q[gi]),
               .data      (data_q[gi])
            );
         end else begin : g_body
            // An item coming from a flushed source arrives as a bubble.
            assign ctrl[gi].load       = load[gi];
            assign ctrl[gi].load_valid = moves[gi-1] & ~fmask[gi-1];
            assign ctrl[gi].kill       = fmask[gi];
            pipe_stage_reg #(
               .DATA_W    (DATA_W)
            ) u_reg (
               .clk       (clk),
               .rst       (rst),
               .ctrl      (ctrl[gi]),
               .load_data (data_q[gi-1]),
               .valid     (valid_q[gi]),
               .data      (data_q[gi])
            );
         end
         assign stage_data[gi*DATA_W +: DATA_W] = data_q[gi];
      end
   endgenerate

   assign stage_valid = valid_q;
   assign out_valid   = valid_q[STAGES-1];
   assign out_data    = data_q[STAGES-1];

   // Popcount of the registered valid bits.
   always_comb begin : popcount
      occ_next = '0;
      for (int k = 0; k < STAGES; k++) begin
         occ_next = occ_next + OCC_W'(valid_q[k]);
      end
   end

   assign occupancy = occ_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired_reg <= '0;
      end else if (moves[STAGES-1]) begin
         retired_reg <= retired_reg + CNT_W'(1);
      end
   end

   assign retired = retired_reg;

`ifdef PIPE_STAGE_CHAIN_PERF_EN
   logic [CNT_W-1:0] stall_cnt_reg;
   logic [CNT_W-1:0] bubble_cnt_reg;
   logic             blocked;

   assign blocked = |(valid_q & ~moves);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_reg  <= '0;
         bubble_cnt_reg <= '0;
      end else begin
         if (en && blocked) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
         end
         if (en && !valid_q[STAGES-1]) begin
            bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);
         end
      end
   end

   assign stall_cycles  = stall_cnt_reg;
   assign bubble_cycles = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_chain
// Directed, table-driven bench for pipe_stage_chain (STAGES=5, DATA_W=32).
// -----------------------------------------------------------------------------
module tb_pipe_stage_chain;
   import pipe_pkg::*;

   localparam int DATA_W = 32;
   localparam int STAGES = 5;
   localparam int CNT_W  = 32;
   localparam int OCC_W  = occ_w(STAGES);

   logic                     clk;
   logic                     rst;
   logic                     in_valid;
   logic [DATA_W-1:0]        in_data;
   logic                     in_ready;
   logic [STAGES-1:0]        stall_req;
   logic [STAGES-1:0]        flush;
   logic                     step_mode;
   logic                     step_pulse;
   logic                     out_valid;
   logic [DATA_W-1:0]        out_data;
   logic                     out_ready;
   logic [STAGES-1:0]        stage_valid;
   logic [STAGES*DATA_W-1:0] stage_data;
   logic [OCC_W-1:0]         occupancy;
   logic [CNT_W-1:0]         retired;
`ifdef PIPE_STAGE_CHAIN_PERF_EN
   logic [CNT_W-1:0]         stall_cycles;
   logic [CNT_W-1:0]         bubble_cycles;
`endif

   int checks = 0;
   int errors = 0;

   pipe_stage_chain #(
      .DATA_W (DATA_W),
      .STAGES (STAGES),
      .CNT_W  (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .stall_req   (stall_req),
      .flush       (flush),
      .step_mode   (step_mode),
      .step_pulse  (step_pulse),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .stage_valid (stage_valid),
      .stage_data  (stage_data),
      .occupancy   (occupancy),
      .retired     (retired)
`ifdef PIPE_STAGE_CHAIN_PERF_EN
      ,
      .stall_cycles  (stall_cycles),
      .bubble_cycles (bubble_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic              iv;
      logic [DATA_W-1:0] id;
      logic [STAGES-1:0] st;
      logic              ordy;
      logic              e_rdy;
      logic [STAGES-1:0] e_v;
      logic [DATA_W-1:0] e_out;
      logic              chk_s2;
      logic [DATA_W-1:0] e_s2;
      logic              chk_ret;
      logic [CNT_W-1:0]  e_ret;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic iv, input logic [DATA_W-1:0] id,
                      input logic [STAGES-1:0] st, input logic ordy,
                      input logic e_rdy, input logic [STAGES-1:0] e_v,
                      input logic [DATA_W-1:0] e_out,
                      input logic chk_s2, input logic [DATA_W-1:0] e_s2,
                      input logic chk_ret, input logic [CNT_W-1:0] e_ret);
      vec_t v;
      v.iv = iv; v.id = id; v.st = st; v.ordy = ordy;
      v.e_rdy = e_rdy; v.e_v = e_v; v.e_out = e_out;
      v.chk_s2 = chk_s2; v.e_s2 = e_s2; v.chk_ret = chk_ret; v.e_ret = e_ret;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [DATA_W-1:0] id,
                        input logic [STAGES-1:0] st, input logic [STAGES-1:0] fl,
                        input logic ordy);
      in_valid  = iv;
      in_data   = id;
      stall_req = st;
      flush     = fl;
      out_ready = ordy;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DATA_W-1:0] sdata(input int k);
      return stage_data[k*DATA_W +: DATA_W];
   endfunction

   initial begin
      int np;
      logic pulse;

      // ---------------- reset state ----------------
      rst = 1'b1;
      drive(1'b1, 32'h0, '0, '0, 1'b1);
      step_mode = 1'b0;
      step_pulse = 1'b0;
      #2;
      chk("rst_valid", 64'(stage_valid), 64'(0));
      chk("rst_occ", 64'(occupancy), 64'(0));
      chk("rst_retired", 64'(retired), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      $display("reset: valid=%b occ=%0d in_ready=%0b", stage_valid, occupancy, in_ready);
      drive(1'b0, 32'h0, '0, '0, 1'b1);
      @(posedge clk);
      #3 rst = 1'b0;
      tick;

      // ---------------- vector tables ----------------
      // streaming 1..8, latency STAGES-1 edges
      add(1, 32'h1, 5'b0, 1, 1, 5'b00001, 32'h0, 0, 32'h0, 0, 0);
      add(1, 32'h2, 5'b0, 1, 1, 5'b00011, 32'h0, 0, 32'h0, 0, 0);
      add(1, 32'h3, 5'b0, 1, 1, 5'b00111, 32'h0, 1, 32'h1, 0, 0);
      add(1, 32'h4, 5'b0, 1, 1, 5'b01111, 32'h0, 1, 32'h2, 0, 0);
      add(1, 32'h5, 5'b0, 1, 1, 5'b11111, 32'h1, 1, 32'h3, 0, 0);
      add(1, 32'h6, 5'b0, 1, 1, 5'b11111, 32'h2, 1, 32'h4, 0, 0);
      add(1, 32'h7, 5'b0, 1, 1, 5'b11111, 32'h3, 1, 32'h5, 0, 0);
      add(1, 32'h8, 5'b0, 1, 1, 5'b11111, 32'h4, 1, 32'h6, 0, 0);
      add(0, 32'h0, 5'b0, 1, 1, 5'b11110, 32'h5, 1, 32'h7, 0, 0);
      add(0, 32'h0, 5'b0, 1, 1, 5'b11100, 32'h6, 1, 32'h8, 0, 0);
      add(0, 32'h0, 5'b0, 1, 1, 5'b11000, 32'h7, 0, 32'h0, 0, 0);
      add(0, 32'h0, 5'b0, 1, 1, 5'b10000, 32'h8, 0, 32'h0, 0, 0);
      add(0, 32'h0, 5'b0, 1, 1, 5'b00000, 32'h0, 0, 32'h0, 1, 8);
      // stall_req[2] for 3 cycles with full streaming
      add(1, 32'h11, 5'b00000, 1, 1, 5'b00001, 32'h0,  0, 32'h0,  0, 0);
      add(1, 32'h12, 5'b00000, 1, 1, 5'b00011, 32'h0,  0, 32'h0,  0, 0);
      add(1, 32'h13, 5'b00000, 1, 1, 5'b00111, 32'h0,  1, 32'h11, 0, 0);
      add(1, 32'h14, 5'b00000, 1, 1, 5'b01111, 32'h0,  1, 32'h12, 0, 0);
      add(1, 32'h15, 5'b00100, 1, 0, 5'b10111, 32'h11, 1, 32'h12, 0, 0);
      add(1, 32'h15, 5'b00100, 1, 0, 5'b00111, 32'h0,  1, 32'h12, 0, 0);
      add(1, 32'h15, 5'b00100, 1, 0, 5'b00111, 32'h0,  1, 32'h12, 0, 0);
      add(1, 32'h15, 5'b00000, 1, 1, 5'b01111, 32'h0,  1, 32'h13, 0, 0);
      add(1, 32'h16, 5'b00000, 1, 1, 5'b11111, 32'h12, 1, 32'h14, 0, 0);
      add(0, 32'h0,  5'b00000, 1, 1, 5'b11110, 32'h13, 1, 32'h15, 0, 0);
      add(0, 32'h0,  5'b00000, 1, 1, 5'b11100, 32'h14, 1, 32'h16, 0, 0);
      add(0, 32'h0,  5'b00000, 1, 1, 5'b11000, 32'h15, 0, 32'h0,  0, 0);
      add(0, 32'h0,  5'b00000, 1, 1, 5'b10000, 32'h16, 0, 32'h0,  0, 0);
      add(0, 32'h0,  5'b00000, 1, 1, 5'b00000, 32'h0,  0, 32'h0,  1, 14);
      // back-pressure: out_ready=0 for 6 cycles, then drain
      add(1, 32'h21, 5'b0, 0, 1, 5'b00001, 32'h0,  0, 32'h0,  0, 0);
      add(1, 32'h22, 5'b0, 0, 1, 5'b00011, 32'h0,  0, 32'h0,  0, 0);
      add(1, 32'h23, 5'b0, 0, 1, 5'b00111, 32'h0,  1, 32'h21, 0, 0);
      add(1, 32'h24, 5'b0, 0, 1, 5'b01111, 32'h0,  1, 32'h22, 0, 0);
      add(1, 32'h25, 5'b0, 0, 1, 5'b11111, 32'h21, 1, 32'h23, 0, 0);
      add(1, 32'h26, 5'b0, 0, 0, 5'b11111, 32'h21, 1, 32'h23, 0, 0);
      add(1, 32'h26, 5'b0, 1, 1, 5'b11111, 32'h22, 1, 32'h24, 0, 0);
      add(0, 32'h0,  5'b0, 1, 1, 5'b11110, 32'h23, 1, 32'h25, 0, 0);
      add(0, 32'h0,  5'b0, 1, 1, 5'b11100, 32'h24, 1, 32'h26, 0, 0);
      add(0, 32'h0,  5'b0, 1, 1, 5'b11000, 32'h25, 0, 32'h0,  0, 0);
      add(0, 32'h0,  5'b0, 1, 1, 5'b10000, 32'h26, 0, 32'h0,  0, 0);
      add(0, 32'h0,  5'b0, 1, 1, 5'b00000, 32'h0,  0, 32'h0,  1, 20);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].iv, tbl[i].id, tbl[i].st, '0, tbl[i].ordy);
         #1;
         chk("vec_in_ready", 64'(in_ready), 64'(tbl[i].e_rdy));
         tick;
         chk("vec_valid", 64'(stage_valid), 64'(tbl[i].e_v));
         chk("vec_occ", 64'(occupancy), 64'($countones(tbl[i].e_v)));
         chk("vec_out_valid", 64'(out_valid), 64'(tbl[i].e_v[STAGES-1]));
         if (tbl[i].e_v[STAGES-1])
            chk("vec_out_data", 64'(out_data), 64'(tbl[i].e_out));
         if (tbl[i].chk_s2)
            chk("vec_s2_data", 64'(sdata(2)), 64'(tbl[i].e_s2));
         if (tbl[i].chk_ret)
            chk("vec_retired", 64'(retired), 64'(tbl[i].e_ret));
         $display("vec %0d: in_v=%0b in_d=%0h stall=%b out_rdy=%0b valid=%b out=%0h ret=%0d",
                  i, tbl[i].iv, tbl[i].id, tbl[i].st, tbl[i].ordy, stage_valid, out_data, retired);
      end

      // ---------------- flush vs stall ----------------
      drive(1'b1, 32'h31, '0, '0, 1'b1); tick;
      drive(1'b1, 32'h32, '0, '0, 1'b1); tick;
      drive(1'b1, 32'h33, '0, '0, 1'b1); tick;
      chk("fl_fill", 64'(stage_valid), 64'(5'b00111));
      drive(1'b1, 32'h34, 5'b00010, 5'b00010, 1'b1);
      #1;
      chk("fl_in_ready", 64'(in_ready), 64'(0));
      tick;
      chk("fl_valid", 64'(stage_valid), 64'(5'b01000));
      chk("fl_occ", 64'(occupancy), 64'(1));
      chk("fl_s3_data", 64'(sdata(3)), 64'(32'h31));
      $display("flush+stall: valid=%b occ=%0d", stage_valid, occupancy);
      drive(1'b0, 32'h0, '0, '0, 1'b1); tick;
      chk("fl_out_data", 64'(out_data), 64'(32'h31));
      chk("fl_out_valid", 64'(out_valid), 64'(1));
      tick;
      chk("fl_drain", 64'(stage_valid), 64'(0));
      chk("fl_retired", 64'(retired), 64'(21));
      // a flush on stage 0 alone still blocks input
      drive(1'b1, 32'h35, '0, 5'b00001, 1'b1);
      #1;
      chk("fl0_in_ready", 64'(in_ready), 64'(0));
      tick;
      chk("fl0_valid", 64'(stage_valid), 64'(0));
      $display("flush0: valid=%b", stage_valid);

      // ---------------- step mode ----------------
      drive(1'b0, 32'h0, '0, '0, 1'b1);
      step_mode = 1'b1;
      np = 0;
      for (int c = 0; c < 10; c++) begin
         pulse = (c == 1) || (c == 4) || (c == 7);
         in_valid = 1'b1;
         in_data = 32'h41 + 32'(np);
         step_pulse = pulse;
         #1;
         chk("step_in_ready", 64'(in_ready), 64'(pulse));
         tick;
         if (pulse) np++;
         if (c == 2) chk("step_mid_valid", 64'(stage_valid), 64'(5'b00001));
         $display("step %0d: pulse=%0b valid=%b", c, pulse, stage_valid);
      end
      step_pulse = 1'b0;
      chk("step_valid", 64'(stage_valid), 64'(5'b00111));
      chk("step_occ", 64'(occupancy), 64'(3));
      chk("step_s2", 64'(sdata(2)), 64'(32'h41));
      chk("step_s0", 64'(sdata(0)), 64'(32'h43));
      drive(1'b0, 32'h0, '0, 5'b10000, 1'b1);
      tick;
      chk("step_flush_valid", 64'(stage_valid), 64'(0));
      chk("step_flush_occ", 64'(occupancy), 64'(0));
      $display("step flush: valid=%b", stage_valid);
      step_mode = 1'b0;

      // ---------------- reset mid-stream ----------------
      drive(1'b1, 32'h51, '0, '0, 1'b1); tick;
      drive(1'b1, 32'h52, '0, '0, 1'b1); tick;
      drive(1'b1, 32'h53, '0, '0, 1'b1); tick;
      chk("mr_fill", 64'(stage_valid), 64'(5'b00111));
      chk("mr_retired_pre", 64'(retired), 64'(21));
      drive(1'b1, 32'h54, '0, '0, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("mr_valid", 64'(stage_valid), 64'(0));
      chk("mr_occ", 64'(occupancy), 64'(0));
      chk("mr_retired", 64'(retired), 64'(0));
      chk("mr_in_ready", 64'(in_ready), 64'(0));
      $display("mid reset: valid=%b occ=%0d ret=%0d rdy=%0b", stage_valid, occupancy, retired, in_ready);
      tick;
      chk("mr_hold", 64'(stage_valid), 64'(0));
      rst = 1'b0;
      drive(1'b1, 32'h61, '0, '0, 1'b1);
      #1;
      chk("mr_resume_rdy", 64'(in_ready), 64'(1));
      tick;
      chk("mr_resume_valid", 64'(stage_valid), 64'(5'b00001));
      chk("mr_resume_s0", 64'(sdata(0)), 64'(32'h61));
      $display("resume: valid=%b s0=%0h", stage_valid, sdata(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
